// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches between fetch and execute. Resolves the
// oldest entry, emits a predictor update, and flushes/redirects on a mispredict.
module branch_resolve_queue #(
  parameter int PC_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     pred_valid,
  input  logic [PC_W-1:0]          pred_pc,
  input  logic                     pred_taken,
  input  logic [PC_W-1:0]          pred_target,
  input  logic [PC_W-1:0]          pred_fallthru,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [PC_W-1:0]          res_target,
  output logic                     upd_valid,
  output logic [PC_W-1:0]          upd_pc,
  output logic                     upd_taken,
  output logic                     flush,
  output logic [PC_W-1:0]          redirect_pc,
  output logic [CNT_W-1:0]         mispredict_cnt,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     res_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL = OW'(DEPTH);

  logic [PC_W-1:0]  pc_q       [DEPTH];
  logic             taken_q    [DEPTH];
  logic [PC_W-1:0]  target_q   [DEPTH];
  logic [PC_W-1:0]  fallthru_q [DEPTH];

  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             upd_valid_q, upd_taken_q, flush_q, res_err_q;
  logic [PC_W-1:0]  upd_pc_q, redirect_q;
  logic [CNT_W-1:0] cnt_q;

  logic res_acc_s, push_acc_s, mispredict_s;

  assign pred_ready   = (occ_q != FULL);
  assign res_acc_s    = res_valid && (occ_q != {OW{1'b0}});
  assign mispredict_s = res_acc_s && ((res_taken != taken_q[head_q]) ||
                        (res_taken && (res_target != target_q[head_q])));
  // A mispredict squashes the whole queue, so any same-cycle push is wrong-path.
  assign push_acc_s   = pred_valid && pred_ready && !mispredict_s;

  // Next head/tail/occupancy pointers.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (mispredict_s) begin
      head_d = {AW{1'b0}};
      tail_d = {AW{1'b0}};
      occ_d  = {OW{1'b0}};
    end else begin
      if (push_acc_s) tail_d = tail_q + AW'(1);
      else            tail_d = tail_q;
      if (res_acc_s)  head_d = head_q + AW'(1);
      else            head_d = head_q;
      case ({push_acc_s, res_acc_s})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]       <= {PC_W{1'b0}};
        taken_q[i]    <= 1'b0;
        target_q[i]   <= {PC_W{1'b0}};
        fallthru_q[i] <= {PC_W{1'b0}};
      end
    end else if (push_acc_s) begin
      pc_q[tail_q]       <= pred_pc;
      taken_q[tail_q]    <= pred_taken;
      target_q[tail_q]   <= pred_target;
      fallthru_q[tail_q] <= pred_fallthru;
    end
  end

  // Pointers, registered resolve outputs and counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q      <= {AW{1'b0}};
      tail_q      <= {AW{1'b0}};
      occ_q       <= {OW{1'b0}};
      upd_valid_q <= 1'b0;
      upd_pc_q    <= {PC_W{1'b0}};
      upd_taken_q <= 1'b0;
      flush_q     <= 1'b0;
      redirect_q  <= {PC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      res_err_q   <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      upd_valid_q <= res_acc_s;
      flush_q     <= mispredict_s;
      if (res_acc_s) begin
        upd_pc_q    <= pc_q[head_q];
        upd_taken_q <= res_taken;
      end
      if (mispredict_s) begin
        redirect_q <= res_taken ? res_target : fallthru_q[head_q];
        if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
      end
      if (res_valid && (occ_q == {OW{1'b0}})) res_err_q <= 1'b1;
    end
  end

  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_taken      = upd_taken_q;
  assign flush          = flush_q;
  assign redirect_pc    = redirect_q;
  assign mispredict_cnt = cnt_q;
  assign occupancy      = occ_q;
  assign res_err        = res_err_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed testbench for branch_resolve_queue: hand-computed expectations per scenario.
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pred_valid = 1'b0, pred_taken = 1'b0;
  logic [15:0] pred_pc = 16'h0, pred_target = 16'h0, pred_fallthru = 16'h0;
  logic        pred_ready;
  logic        res_valid = 1'b0, res_taken = 1'b0;
  logic [15:0] res_target = 16'h0;
  logic        upd_valid, upd_taken, flush, res_err;
  logic [15:0] upd_pc, redirect_pc, mispredict_cnt;
  logic [2:0]  occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  branch_resolve_queue #(.PC_W(16), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_fallthru(pred_fallthru), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .flush(flush), .redirect_pc(redirect_pc), .mispredict_cnt(mispredict_cnt),
    .occupancy(occupancy), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, take the edge, outputs are then stable for checking.
  task automatic cyc(input logic pv, input logic [15:0] pc, input logic pt,
                     input logic [15:0] ptg, input logic rv, input logic rt,
                     input logic [15:0] rtg);
    pred_valid = pv; pred_pc = pc; pred_taken = pt; pred_target = ptg;
    pred_fallthru = pc + 16'd1;
    res_valid = rv; res_taken = rt; res_target = rtg;
    @(posedge clk); #1;
    pred_valid = 1'b0; res_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    reset_n = 1'b1;
    n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    n_cmp++; if (pred_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", pred_ready); end
    n_cmp++; if ({upd_valid, flush, res_err} !== 3'b000) begin n_bad++; $display("FAIL reset_strobes: got %b want 000", {upd_valid, flush, res_err}); end
    n_cmp++; if (mispredict_cnt !== 16'h0 || redirect_pc !== 16'h0 || upd_pc !== 16'h0) begin n_bad++; $display("FAIL reset_values: cnt %h redir %h upd_pc %h want 0", mispredict_cnt, redirect_pc, upd_pc); end
  endtask

  task automatic test_basic();
    cyc(1'b1, 16'h0010, 1'b1, 16'h0020, 1'b0, 1'b0, 16'h0);
    n_cmp++; if (occupancy !== 3'd1) begin n_bad++; $display("FAIL basic_push_occ: got %0d want 1", occupancy); end
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0020);
    n_cmp++; if ({upd_valid, upd_taken, flush} !== 3'b110) begin n_bad++; $display("FAIL basic_strobes: got %b want 110", {upd_valid, upd_taken, flush}); end
    n_cmp++; if (upd_pc !== 16'h0010) begin n_bad++; $display("FAIL basic_upd_pc: got %h want 0010", upd_pc); end
    n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL basic_pop_occ: got %0d want 0", occupancy); end
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    n_cmp++; if (upd_valid !== 1'b0) begin n_bad++; $display("FAIL basic_pulse: got %b want 0", upd_valid); end
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'h0100 + 16'(i), 1'b0, 16'h0200, 1'b0, 1'b0, 16'h0);
    n_cmp++; if (occupancy !== 3'd4) begin n_bad++; $display("FAIL fill_occ: got %0d want 4", occupancy); end
    n_cmp++; if (pred_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready: got %b want 0", pred_ready); end
    cyc(1'b1, 16'h0104, 1'b0, 16'h0200, 1'b0, 1'b0, 16'h0);
    n_cmp++; if (occupancy !== 3'd4) begin n_bad++; $display("FAIL fill_overflow: got %0d want 4", occupancy); end
    // Push alongside a pop while full: pred_ready is 0 so the push is dropped.
    cyc(1'b1, 16'h0105, 1'b0, 16'h0200, 1'b1, 1'b0, 16'h0);
    n_cmp++; if (occupancy !== 3'd3) begin n_bad++; $display("FAIL full_pushpop_occ: got %0d want 3", occupancy); end
    n_cmp++; if (upd_pc !== 16'h0100 || flush !== 1'b0) begin n_bad++; $display("FAIL fill_order0: upd_pc %h flush %b want 0100 0", upd_pc, flush); end
    for (int i = 1; i < 4; i++) begin
      cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
      n_cmp++; if (upd_pc !== 16'h0100 + 16'(i) || upd_valid !== 1'b1 || upd_taken !== 1'b0) begin n_bad++; $display("FAIL fill_order%0d: upd_pc %h valid %b taken %b want %h 1 0", i, upd_pc, upd_valid, upd_taken, 16'h0100 + 16'(i)); end
    end
    n_cmp++; if (occupancy !== 3'd0 || pred_ready !== 1'b1) begin n_bad++; $display("FAIL fill_drained: occ %0d ready %b want 0 1", occupancy, pred_ready); end
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 16'h0300, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 16'h0301, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    n_cmp++; if (occupancy !== 3'd1 || upd_pc !== 16'h0300) begin n_bad++; $display("FAIL b2b_first: occ %0d upd_pc %h want 1 0300", occupancy, upd_pc); end
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    n_cmp++; if (occupancy !== 3'd0 || upd_pc !== 16'h0301) begin n_bad++; $display("FAIL b2b_second: occ %0d upd_pc %h want 0 0301", occupancy, upd_pc); end
  endtask

  task automatic test_mispredict_dir();
    cyc(1'b1, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 16'h0006, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 16'h0007, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0);
    // Resolve mispredicted with a wrong-path push in the same cycle.
    cyc(1'b1, 16'h0050, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0030);
    n_cmp++; if (flush !== 1'b1 || redirect_pc !== 16'h0030) begin n_bad++; $display("FAIL mp_dir_redirect: flush %b redir %h want 1 0030", flush, redirect_pc); end
    n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL mp_dir_occ: got %0d want 0", occupancy); end
    n_cmp++; if (mispredict_cnt !== 16'd1) begin n_bad++; $display("FAIL mp_dir_cnt: got %0d want 1", mispredict_cnt); end
    n_cmp++; if (upd_valid !== 1'b1 || upd_pc !== 16'h0005 || upd_taken !== 1'b1) begin n_bad++; $display("FAIL mp_dir_upd: %b %h %b want 1 0005 1", upd_valid, upd_pc, upd_taken); end
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    n_cmp++; if (flush !== 1'b0 || redirect_pc !== 16'h0030) begin n_bad++; $display("FAIL mp_dir_after: flush %b redir %h want 0 0030", flush, redirect_pc); end
  endtask

  task automatic test_mispredict_target();
    cyc(1'b1, 16'h0041, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0044);
    n_cmp++; if (flush !== 1'b1 || redirect_pc !== 16'h0044) begin n_bad++; $display("FAIL mp_tgt_redirect: flush %b redir %h want 1 0044", flush, redirect_pc); end
    n_cmp++; if (mispredict_cnt !== 16'd2) begin n_bad++; $display("FAIL mp_tgt_cnt: got %0d want 2", mispredict_cnt); end
  endtask

  task automatic test_taken_not_taken_and_empty();
    cyc(1'b1, 16'h0008, 1'b1, 16'h0070, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0070);
    n_cmp++; if (flush !== 1'b1 || redirect_pc !== 16'h0009 || upd_taken !== 1'b0) begin n_bad++; $display("FAIL mp_nt: flush %b redir %h taken %b want 1 0009 0", flush, redirect_pc, upd_taken); end
    n_cmp++; if (mispredict_cnt !== 16'd3 || res_err !== 1'b0) begin n_bad++; $display("FAIL mp_nt_cnt: cnt %0d err %b want 3 0", mispredict_cnt, res_err); end
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0001);
    n_cmp++; if (res_err !== 1'b1 || upd_valid !== 1'b0 || flush !== 1'b0) begin n_bad++; $display("FAIL empty_res: err %b upd %b flush %b want 1 0 0", res_err, upd_valid, flush); end
    n_cmp++; if (occupancy !== 3'd0 || mispredict_cnt !== 16'd3) begin n_bad++; $display("FAIL empty_state: occ %0d cnt %0d want 0 3", occupancy, mispredict_cnt); end
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    n_cmp++; if (res_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", res_err); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0400 + 16'(i), 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    n_cmp++; if (occupancy !== 3'd3) begin n_bad++; $display("FAIL mid_pre_occ: got %0d want 3", occupancy); end
    reset_n = 1'b0;
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0099);
    reset_n = 1'b1;
    n_cmp++; if (occupancy !== 3'd0 || pred_ready !== 1'b1) begin n_bad++; $display("FAIL mid_occ: occ %0d ready %b want 0 1", occupancy, pred_ready); end
    n_cmp++; if ({flush, upd_valid, res_err} !== 3'b000) begin n_bad++; $display("FAIL mid_strobes: got %b want 000", {flush, upd_valid, res_err}); end
    n_cmp++; if (mispredict_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_cnt: got %0d want 0", mispredict_cnt); end
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    n_cmp++; if (upd_valid !== 1'b0 || res_err !== 1'b1) begin n_bad++; $display("FAIL mid_discarded: upd %b err %b want 0 1", upd_valid, res_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_wrap();
    test_back_to_back();
    test_mispredict_dir();
    test_mispredict_target();
    test_taken_not_taken_and_empty();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
